// File: rtl/posit_fma_round_encode.sv
// posit_fma_round_encode: two-stage posit regime/exponent/fraction assembly with RNE rounding and saturation.
module posit_fma_round_encode #(
  parameter int N = 32,
  parameter int ES = 2,
  parameter int RS = $clog2(N),
  parameter int SW = ES + RS + 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_sign,
  input  logic [SW-1:0]   in_scale,
  input  logic [2*N-1:0]  in_mant,
  input  logic            in_inf,
  input  logic            in_zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_posit,
  output logic            out_nar,
  output logic            out_zero
);
  localparam int KW = SW - ES;
  localparam int WZ = 3 * N + ES + 1;
  localparam logic signed [KW-1:0] K_HI = KW'(N - 2);
  localparam logic signed [KW-1:0] K_LO = KW'(-(N - 1));
  localparam logic [N-1:0] MAXP = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINP = N'(1);
  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};
  logic                 s1_valid, s1_sign, s1_inf, s1_zero, s1_hi, s1_lo;
  logic signed [KW-1:0] s1_k, k;
  logic [ES-1:0]        s1_e;
  logic [2*N-2:0]       s1_frac;
  logic                 adv1, adv2, neg, guard, sticky, rnd, unused_hidden;
  logic [KW-1:0]        sh;
  logic signed [WZ-1:0] z0, z;
  logic [N-2:0]         mag;
  logic [N-1:0]         sum, mag_f, pos, res;
  assign unused_hidden = in_mant[2*N-1];
  assign adv2 = ~out_valid | out_ready;
  assign adv1 = ~s1_valid | adv2;
  assign in_ready = adv1;
  assign k = in_scale[SW-1:ES];
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_k     <= '0;
      s1_e     <= '0;
      s1_frac  <= '0;
      s1_inf   <= 1'b0;
      s1_zero  <= 1'b0;
      s1_hi    <= 1'b0;
      s1_lo    <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      s1_sign  <= in_sign;
      s1_k     <= k;
      s1_e     <= in_scale[ES-1:0];
      s1_frac  <= in_mant[2*N-2:0];
      s1_inf   <= in_inf;
      s1_zero  <= in_zero;
      s1_hi    <= k >= K_HI;
      s1_lo    <= k <= K_LO;
    end
  end
  // Regime is formed by arithmetic-shifting {fill, terminator, e, frac}: fill replicates into the run.
  assign neg = s1_k[KW-1];
  assign sh = s1_k ^ {KW{neg}};
  assign z0 = {~neg, neg, s1_e, s1_frac, {N{1'b0}}};
  assign z = z0 >>> sh;
  assign mag = z[WZ-1 -: N-1];
  assign guard = z[WZ-N];
  assign sticky = |z[WZ-N-1:0];
  assign rnd = guard & (sticky | mag[0]);
  assign sum = {1'b0, mag} + {{(N-1){1'b0}}, rnd};
  always_comb begin
    mag_f = s1_hi ? MAXP : s1_lo ? MINP : sum[N-1] ? MAXP : ~|sum ? MINP : sum;
    pos = s1_sign ? -mag_f : mag_f;
    res = s1_inf ? NAR : s1_zero ? '0 : pos;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_posit <= '0;
      out_nar   <= 1'b0;
      out_zero  <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_posit <= res;
        out_nar   <= s1_inf;
        out_zero  <= ~s1_inf & s1_zero;
      end
    end
  end
endmodule

// File: tb/tb_posit_fma_round_encode.sv
// tb_posit_fma_round_encode: directed vectors, handshake streaming and reset checks.
module tb_posit_fma_round_encode;
  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0, in_ready, in_sign = 0, in_inf = 0, in_zero = 0;
  logic [8:0]  in_scale = '0;
  logic [63:0] in_mant = '0;
  logic        out_valid, out_ready = 1, out_nar, out_zero;
  logic [31:0] out_posit;
  int total = 0, bad = 0;
  localparam logic [63:0] ONE = 64'h8000_0000_0000_0000;
  logic [31:0] tbl [8] = '{32'h4000_0000, 32'h6000_0000, 32'h7000_0000, 32'h7800_0000,
                           32'h7C00_0000, 32'h7E00_0000, 32'h7F00_0000, 32'h7F80_0000};

  posit_fma_round_encode dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_scale(in_scale), .in_mant(in_mant), .in_inf(in_inf), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_posit(out_posit),
    .out_nar(out_nar), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_vec(input string tag, input bit sg, input logic [8:0] sc, input logic [63:0] mt,
                         input bit inf, input bit zr, input logic [31:0] ep, input bit en, input bit ez);
    @(negedge clk);
    in_valid = 1; in_sign = sg; in_scale = sc; in_mant = mt; in_inf = inf; in_zero = zr; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    for (int c = 0; c < 5 && !out_valid; c++) @(negedge clk);
    chk({tag, "_valid"}, {31'b0, out_valid}, 1);
    chk(tag, out_posit, ep);
    chk({tag, "_nar"}, {31'b0, out_nar}, {31'b0, en});
    chk({tag, "_zero"}, {31'b0, out_zero}, {31'b0, ez});
  endtask

  initial begin
    int sent, rcv, got;
    logic held_v;
    logic [31:0] held;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_posit", out_posit, 0);
    chk("rst_flags", {30'b0, out_nar, out_zero}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 1);

    run_vec("one",      0, 9'd0,   ONE, 0, 0, 32'h4000_0000, 0, 0);
    run_vec("neg_one",  1, 9'd0,   ONE, 0, 0, 32'hC000_0000, 0, 0);
    run_vec("scale_p1", 0, 9'd1,   ONE, 0, 0, 32'h4800_0000, 0, 0);
    run_vec("scale_m1", 0, 9'h1FF, ONE, 0, 0, 32'h3800_0000, 0, 0);
    run_vec("tie_even", 0, 9'd0, 64'h8000_0008_0000_0000, 0, 0, 32'h4000_0000, 0, 0);
    run_vec("above_tie",0, 9'd0, 64'h8000_0008_0000_0001, 0, 0, 32'h4000_0001, 0, 0);
    run_vec("tie_odd",  0, 9'd0, 64'h8000_0018_0000_0000, 0, 0, 32'h4000_0002, 0, 0);
    run_vec("sat_hi",   0, 9'd200, ONE, 0, 0, 32'h7FFF_FFFF, 0, 0);
    run_vec("sat_lo",   0, 9'h138, ONE, 0, 0, 32'h0000_0001, 0, 0);
    run_vec("sat_hi_n", 1, 9'd200, ONE, 0, 0, 32'h8000_0001, 0, 0);
    run_vec("sat_lo_n", 1, 9'h138, ONE, 0, 0, 32'hFFFF_FFFF, 0, 0);
    run_vec("nar",      0, 9'd0,   ONE, 1, 1, 32'h8000_0000, 1, 0);
    run_vec("zero",     1, 9'd5,   ONE, 0, 1, 32'h0000_0000, 0, 1);

    // random backpressure stream
    @(negedge clk);
    sent = 0; rcv = 0; held_v = 0; held = '0;
    for (int c = 0; c < 300 && rcv < 8; c++) begin
      @(negedge clk);
      if (held_v) chk("stall_hold", out_posit, held);
      out_ready = 1'($urandom_range(0, 1));
      in_valid = sent < 8; in_sign = 0; in_inf = 0; in_zero = 0; in_mant = ONE;
      in_scale = 9'(4 * sent);
      #1;
      chk("stream_in_ready", {31'b0, in_ready}, {31'b0, !((sent - rcv) == 2 && !out_ready)});
      if (out_valid && out_ready) begin
        chk("stream_order", out_posit, tbl[rcv]);
        rcv++;
      end
      held_v = out_valid && !out_ready;
      held = out_posit;
      if (in_valid && in_ready) sent++;
    end
    chk("stream_count", 32'(rcv), 8);

    // back-to-back throughput
    @(negedge clk);
    in_valid = 0; out_ready = 1; sent = 0; got = 0;
    for (int c = 0; c < 30 && got < 8; c++) begin
      @(negedge clk);
      in_valid = sent < 8; in_scale = 9'(4 * sent);
      #1;
      if (in_valid) chk("tput_in_ready", {31'b0, in_ready}, 1);
      if (got > 0 || out_valid) begin
        chk("tput_no_gap", {31'b0, out_valid}, 1);
        if (out_valid) chk("tput_data", out_posit, tbl[got]);
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    chk("tput_count", 32'(got), 8);

    // reset with two beats in flight
    @(negedge clk);
    out_ready = 0; in_valid = 1; in_scale = 9'd4;
    @(negedge clk);
    in_scale = 9'd8;
    @(negedge clk);
    in_valid = 0;
    #1;
    chk("full_in_ready", {31'b0, in_ready}, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 0);
    chk("mid_rst_posit", out_posit, 0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 1);
    out_ready = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("no_stale", {31'b0, out_valid}, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
